adder_stim_capture: RTL and testbench

- Test harness stage wrapped around the 8-bit prefix adder.
- Upstream role: drives registered operands `a`, `b`, `cin` into the adder.
- Downstream role: after a programmable settle interval, captures the adder's `sum`/`cout` and checks them against a behavioural `a+b+cin`.
- Supports multi-vector sweeps, with `b` incremented per vector. Counts runs and mismatches for readout by the instrumentation logic.

---
 rtl/adder_stim_pkg.sv | 29 ++
 rtl/adder_stim_capture_sat_counter.sv | 26 ++
 rtl/adder_stim_capture.sv | 180 ++++++++++++++++++
 tb/tb_adder_stim_capture.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/adder_stim_pkg.sv
// adder_stim_pkg: shared types and constants for the adder stimulus/capture stage.
//   - state_t      : sweep FSM states
//   - DEF_*        : default parameter values
//   - exp_sum()    : behavioural reference a + b + cin, returned MAX_W+1 bits wide
package adder_stim_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_SETTLE_W = 4;
  localparam int DEF_RUN_W    = 16;
  localparam int DEF_ERR_W    = 16;

  // Reference width. Operands are zero-extended into it, so WIDTH must be < MAX_W.
  localparam int MAX_W        = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  function automatic logic [MAX_W:0] exp_sum(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/adder_stim_capture_sat_counter.sv
// sat_counter: up counter that sticks at all-ones.
//   clk     : clock
//   reset   : synchronous active-high reset, clears count
//   i_clr   : synchronous clear (wins over increment)
//   i_inc   : increment request, ignored once saturated
//   o_cnt   : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr)          r_cnt <= '0;
    else if (i_inc && ~&r_cnt)   r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/adder_stim_capture.sv
// adder_stim_capture: drives registered operands into an external adder,
// waits a programmable settle interval, captures sum/cout and checks them
// against a behavioural a+b+cin. A sweep runs run_len vectors with b
// incremented (mod 2^WIDTH) after each one.
//
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   start                          : begin sweep (IDLE only)
//   a_in, b_in, cin_in             : operands latched at start
//   settle_cycles, run_len         : timing / vector count latched at start
//   adder_a, adder_b, adder_cin    : registered operands to the adder
//   adder_sum, adder_cout          : adder result
//   busy, done                     : status (done is a one-cycle pulse)
//   run_count, err_count           : vectors completed, saturating mismatches
//   last_sum, last_cout            : result of the most recent vector
//
// Optional build macro FIRST_FAIL_LOG_EN adds ff_valid/ff_a/ff_b/ff_cin/
// ff_sum/ff_cout, holding the first mismatching vector of the sweep.
module adder_stim_capture
  import adder_stim_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SETTLE_W = DEF_SETTLE_W,
  parameter int RUN_W    = DEF_RUN_W,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    a_in,
  input  logic [WIDTH-1:0]    b_in,
  input  logic                cin_in,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [RUN_W-1:0]    run_len,
  output logic [WIDTH-1:0]    adder_a,
  output logic [WIDTH-1:0]    adder_b,
  output logic                adder_cin,
  input  logic [WIDTH-1:0]    adder_sum,
  input  logic                adder_cout,
  output logic                busy,
  output logic                done,
  output logic [RUN_W-1:0]    run_count,
  output logic [ERR_W-1:0]    err_count,
  output logic [WIDTH-1:0]    last_sum,
`ifdef FIRST_FAIL_LOG_EN
  output logic                last_cout,
  output logic                ff_valid,
  output logic [WIDTH-1:0]    ff_a,
  output logic [WIDTH-1:0]    ff_b,
  output logic                ff_cin,
  output logic [WIDTH-1:0]    ff_sum,
  output logic                ff_cout
`else
  output logic                last_cout
`endif
);

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_a, r_b;
  logic                r_cin;
  logic [SETTLE_W-1:0] r_settle, r_settle_cnt;
  logic [RUN_W-1:0]    r_run_len, r_run_count;
  logic [WIDTH-1:0]    r_last_sum;
  logic                r_last_cout;

  logic                w_latch, w_capture, w_mismatch;
  logic [RUN_W-1:0]    w_run_next;
  logic [MAX_W:0]      w_exp;

  assign w_run_next = r_run_count + RUN_W'(1);
  assign w_exp      = exp_sum(MAX_W'(r_a), MAX_W'(r_b), r_cin);
  // Zero-pad the adder result to the reference width rather than slicing it.
  assign w_mismatch = ({{(MAX_W-WIDTH){1'b0}}, adder_cout, adder_sum} != w_exp);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_latch     = 1'b1;
        w_state_nxt = (run_len == '0) ? S_DONE : S_LAUNCH;
      end
      S_LAUNCH:  w_state_nxt = S_SETTLE;
      S_SETTLE:  if (r_settle_cnt == '0) w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = (w_run_next == r_run_len) ? S_DONE : S_LAUNCH;
      end
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_settle     <= '0;
      r_settle_cnt <= '0;
      r_run_len    <= '0;
      r_run_count  <= '0;
      r_last_sum   <= '0;
      r_last_cout  <= 1'b0;
    end else begin
      if (w_latch) begin
        r_a         <= a_in;
        r_b         <= b_in;
        r_cin       <= cin_in;
        r_settle    <= settle_cycles;
        r_run_len   <= run_len;
        r_run_count <= '0;
      end
      if (r_state == S_LAUNCH) r_settle_cnt <= r_settle;
      else if (r_state == S_SETTLE && r_settle_cnt != '0)
        r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
      if (w_capture) begin
        r_last_sum  <= adder_sum;
        r_last_cout <= adder_cout;
        r_run_count <= w_run_next;
        // b only advances when another vector follows, so the final b stays visible.
        if (w_run_next != r_run_len) r_b <= r_b + WIDTH'(1);
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_latch),
    .i_inc (w_capture && w_mismatch),
    .o_cnt (err_count)
  );

`ifdef FIRST_FAIL_LOG_EN
  logic             r_ff_valid, r_ff_cin, r_ff_cout;
  logic [WIDTH-1:0] r_ff_a, r_ff_b, r_ff_sum;

  always_ff @(posedge clk) begin
    if (reset || w_latch) begin
      r_ff_valid <= 1'b0;
      r_ff_a     <= '0;
      r_ff_b     <= '0;
      r_ff_cin   <= 1'b0;
      r_ff_sum   <= '0;
      r_ff_cout  <= 1'b0;
    end else if (w_capture && w_mismatch && !r_ff_valid) begin
      r_ff_valid <= 1'b1;
      r_ff_a     <= r_a;
      r_ff_b     <= r_b;
      r_ff_cin   <= r_cin;
      r_ff_sum   <= adder_sum;
      r_ff_cout  <= adder_cout;
    end
  end

  assign ff_valid = r_ff_valid;
  assign ff_a     = r_ff_a;
  assign ff_b     = r_ff_b;
  assign ff_cin   = r_ff_cin;
  assign ff_sum   = r_ff_sum;
  assign ff_cout  = r_ff_cout;
`endif

  assign adder_a   = r_a;
  assign adder_b   = r_b;
  assign adder_cin = r_cin;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign run_count = r_run_count;
  assign last_sum  = r_last_sum;
  assign last_cout = r_last_cout;

endmodule

// File: tb/tb_adder_stim_capture.sv
// Directed bench for adder_stim_capture: table of sweeps plus hand-written
// start-interlock and mid-sweep reset sequences. A small adder model with an
// optional sum[3] stuck-at-0 fault sits on the adder ports.
module tb_adder_stim_capture;

  logic        clk = 1'b0;
  logic        reset, start, cin_in;
  logic [7:0]  a_in, b_in;
  logic [3:0]  settle_cycles;
  logic [15:0] run_len;
  logic [7:0]  adder_a, adder_b, adder_sum, last_sum;
  logic        adder_cin, adder_cout, busy, done, last_cout;
  logic [15:0] run_count;
  logic [2:0]  err_count;
`ifdef FIRST_FAIL_LOG_EN
  logic        ff_valid, ff_cin, ff_cout;
  logic [7:0]  ff_a, ff_b, ff_sum;
`endif

  int checks = 0;
  int errors = 0;
  logic fault = 1'b0;
  logic [8:0] m_full;

  always #5 clk = ~clk;

  always_comb begin
    m_full     = {1'b0, adder_a} + {1'b0, adder_b} + {8'h00, adder_cin};
    adder_sum  = m_full[7:0];
    if (fault) adder_sum[3] = 1'b0;
    adder_cout = m_full[8];
  end

  adder_stim_capture #(.WIDTH(8), .SETTLE_W(4), .RUN_W(16), .ERR_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .cin_in(cin_in), .settle_cycles(settle_cycles), .run_len(run_len),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout), .busy(busy), .done(done),
    .run_count(run_count), .err_count(err_count), .last_sum(last_sum),
`ifdef FIRST_FAIL_LOG_EN
    .last_cout(last_cout), .ff_valid(ff_valid), .ff_a(ff_a), .ff_b(ff_b),
    .ff_cin(ff_cin), .ff_sum(ff_sum), .ff_cout(ff_cout)
`else
    .last_cout(last_cout)
`endif
  );

  typedef struct {
    logic [7:0]  a, b;
    logic        cin;
    logic [3:0]  s;
    logic [15:0] n;
    logic        flt;
    int          done_cyc;
    logic [7:0]  e_sum;
    logic        e_cout;
    logic [15:0] e_rc;
    logic [2:0]  e_ec;
    logic [7:0]  e_a, e_b;
    logic        e_ffv;
    logic [7:0]  e_ffb, e_ffs;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'(0));
    chk({tag, "_done"},  32'(done), 32'(0));
    chk({tag, "_a"},     32'(adder_a), 32'(0));
    chk({tag, "_b"},     32'(adder_b), 32'(0));
    chk({tag, "_cin"},   32'(adder_cin), 32'(0));
    chk({tag, "_rc"},    32'(run_count), 32'(0));
    chk({tag, "_ec"},    32'(err_count), 32'(0));
    chk({tag, "_lsum"},  32'(last_sum), 32'(0));
    chk({tag, "_lcout"}, 32'(last_cout), 32'(0));
  endtask

  // Drive a sweep; start is sampled on the next edge (edge 0).
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [3:0] s, input logic [15:0] n, input logic f);
    @(negedge clk);
    a_in = a; b_in = b; cin_in = c; settle_cycles = s; run_len = n; fault = f;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Changing inputs after start must not affect the running sweep.
    a_in = ~a; b_in = ~b; cin_in = ~c; run_len = 16'd5;
  endtask

  // Count negedges after edge 0 until done; cycle 1 is the first.
  task automatic wait_done(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done || cyc >= 200) break;
    end
  endtask

  initial begin
    int cyc, nd;
    //           a      b      cin   s     n       flt   done e_sum  cout rc      ec    e_a    e_b    ffv   ffb    ffs
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 4'd2, 16'd1,  1'b0, 6,  8'h10, 1'b0, 16'd1,  3'd0, 8'h0F, 8'h01, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{8'hFF, 8'hFE, 1'b1, 4'd0, 16'd3,  1'b0, 10, 8'h00, 1'b1, 16'd3,  3'd0, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{8'h08, 8'h00, 1'b0, 4'd1, 16'd4,  1'b1, 17, 8'h03, 1'b0, 16'd4,  3'd4, 8'h08, 8'h03, 1'b1, 8'h00, 8'h00};
    vecs[3] = '{8'h55, 8'hAA, 1'b1, 4'd3, 16'd0,  1'b0, 1,  8'h03, 1'b0, 16'd0,  3'd0, 8'h55, 8'hAA, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 4'd5, 16'd2,  1'b0, 17, 8'h01, 1'b1, 16'd2,  3'd0, 8'h80, 8'h81, 1'b0, 8'h00, 8'h00};
    vecs[5] = '{8'h08, 8'h00, 1'b0, 4'd0, 16'd10, 1'b1, 31, 8'h11, 1'b0, 16'd10, 3'd7, 8'h08, 8'h09, 1'b1, 8'h00, 8'h00};

    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    settle_cycles = '0; run_len = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].n, vecs[i].flt);
      wait_done(cyc);
      chk($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'(vecs[i].done_cyc));
      chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'(1));
      chk($sformatf("v%0d_last_sum", i), 32'(last_sum), 32'(vecs[i].e_sum));
      chk($sformatf("v%0d_last_cout", i), 32'(last_cout), 32'(vecs[i].e_cout));
      chk($sformatf("v%0d_run_count", i), 32'(run_count), 32'(vecs[i].e_rc));
      chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(vecs[i].e_ec));
      chk($sformatf("v%0d_adder_a", i), 32'(adder_a), 32'(vecs[i].e_a));
      chk($sformatf("v%0d_adder_b", i), 32'(adder_b), 32'(vecs[i].e_b));
      chk($sformatf("v%0d_adder_cin", i), 32'(adder_cin), 32'(vecs[i].cin));
`ifdef FIRST_FAIL_LOG_EN
      chk($sformatf("v%0d_ff_valid", i), 32'(ff_valid), 32'(vecs[i].e_ffv));
      chk($sformatf("v%0d_ff_b", i), 32'(ff_b), 32'(vecs[i].e_ffb));
      chk($sformatf("v%0d_ff_sum", i), 32'(ff_sum), 32'(vecs[i].e_ffs));
      chk($sformatf("v%0d_ff_a", i), 32'(ff_a), 32'(vecs[i].e_ffv ? vecs[i].a : 8'h00));
`endif
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'(0));
      chk($sformatf("v%0d_idle_done", i), 32'(done), 32'(0));
      chk($sformatf("v%0d_hold_rc", i), 32'(run_count), 32'(vecs[i].e_rc));
    end

    // start pulsed during SETTLE must be ignored.
    launch(8'h11, 8'h22, 1'b0, 4'd5, 16'd1, 1'b0);
    repeat (3) @(negedge clk);
    a_in = 8'h99; b_in = 8'h01; run_len = 16'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 3;
    forever begin
      @(negedge clk);
      cyc++;
      if (done || cyc >= 200) break;
    end
    chk("ilk_done_cycle", 32'(cyc), 32'(9));
    chk("ilk_adder_a", 32'(adder_a), 32'(8'h11));
    chk("ilk_last_sum", 32'(last_sum), 32'(8'h33));
    chk("ilk_run_count", 32'(run_count), 32'(1));

    // Reset in SETTLE aborts with no done pulse.
    launch(8'h11, 8'h22, 1'b1, 4'd5, 16'd3, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("midrst_no_done", 32'(nd), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
